// File: rtl/sha256_job_arbiter.sv
// Round-robin job controller sharing one SHA-256 compression core between
// N_REQ requesters. It loads a block, waits for completion or a watchdog expiry, and returns the digest.
module sha256_job_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = $clog2(N_REQ),
   parameter int TIMEOUT = 63
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*512-1:0] req_msg,
   output logic [N_REQ-1:0]   req_ready,
   output logic               core_start,
   output logic [511:0]       core_msg,
   input  logic               core_ready,
   input  logic [255:0]       core_hash,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [ID_W-1:0]    rsp_id,
   output logic [255:0]       rsp_hash,
   output logic               rsp_error,
   output logic               busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [1:0]       state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic [511:0]     core_msg_q, core_msg_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [255:0]     rsp_hash_q, rsp_hash_d;
   logic             rsp_error_q, rsp_error_d;

   logic             grant_found;
   logic [ID_W-1:0]  grant_idx;
   logic [ID_W-1:0]  cand_id;
   int unsigned      cand;

   // Search ptr, ptr+1, ... wrapping at N_REQ; the first valid requester wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = 0;
      cand_id     = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = 32'(ptr_q) + k;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cand_id = ID_W'(cand);
         if (!grant_found && req_valid[cand_id]) begin
            grant_found = 1'b1;
            grant_idx   = cand_id;
         end
      end
   end

   // The grant is suppressed while reset is high because that edge discards it.
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && grant_found && !reset)
         req_ready = N_REQ'(1) << grant_idx;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      wd_d        = wd_q;
      core_msg_d  = core_msg_q;
      rsp_id_d    = rsp_id_q;
      rsp_hash_d  = rsp_hash_q;
      rsp_error_d = rsp_error_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               state_d    = S_LOAD;
               core_msg_d = req_msg[512*grant_idx +: 512];
               rsp_id_d   = grant_idx;
               ptr_d      = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
         end
         S_LOAD: begin
            state_d = S_RUN;
            wd_d    = '0;
         end
         S_RUN: begin
            wd_d = wd_q + CNT_W'(1);
            // Completion wins over a watchdog expiry in the same cycle.
            if (core_ready) begin
               rsp_hash_d  = core_hash;
               rsp_error_d = 1'b0;
               state_d     = S_RESP;
            end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
               rsp_hash_d  = '0;
               rsp_error_d = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         wd_q        <= '0;
         core_msg_q  <= '0;
         rsp_id_q    <= '0;
         rsp_hash_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         wd_q        <= wd_d;
         core_msg_q  <= core_msg_d;
         rsp_id_q    <= rsp_id_d;
         rsp_hash_q  <= rsp_hash_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   assign core_start = (state_q == S_IDLE) || (state_q == S_LOAD);
   assign core_msg   = core_msg_q;
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_hash   = rsp_hash_q;
   assign rsp_error  = rsp_error_q;
   assign busy       = (state_q != S_IDLE);

endmodule
